led_pattern_sequencer: RTL

Drives the 8-LED bank through a fixed sequence of display patterns: binary count, rotate, bounce and blink. A prescaler derives a slow tick from the board clock. An FSM holds each pattern for a programmable number of ticks, then advances to the next one. A `step` input lets a pushbutton or host advance the mode early. Sits at top level between the clock/reset pins and the LED pins.

---
 rtl/led_seq_pkg.sv | 48 ++++
 rtl/tick_prescaler.sv | 26 ++
 rtl/led_pattern_sequencer.sv | 82 ++++++++
 3 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED pattern sequencer.
package led_seq_pkg;

  // Display modes, in the order the sequencer steps through them.
  typedef enum logic [1:0] {
    COUNT  = 2'd0,
    SHIFT  = 2'd1,
    BOUNCE = 2'd2,
    BLINK  = 2'd3
  } mode_t;

  // Travel direction of the single lit bit in BOUNCE.
  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  // Pattern loaded on entry to each mode.
  localparam logic [7:0] PAT_COUNT_INIT  = 8'h00;
  localparam logic [7:0] PAT_SHIFT_INIT  = 8'h01;
  localparam logic [7:0] PAT_BOUNCE_INIT = 8'h01;
  localparam logic [7:0] PAT_BLINK_INIT  = 8'h00;

  // BOUNCE end markers where the direction reverses.
  localparam logic [7:0] PAT_MSB = 8'h80;
  localparam logic [7:0] PAT_LSB = 8'h01;

  // Mode that follows m; BLINK wraps back to COUNT.
  function automatic mode_t next_mode(mode_t m);
    case (m)
      COUNT:   return SHIFT;
      SHIFT:   return BOUNCE;
      BOUNCE:  return BLINK;
      default: return COUNT;
    endcase
  endfunction

  // Entry pattern of mode m.
  function automatic logic [7:0] entry_pat(mode_t m);
    case (m)
      COUNT:   return PAT_COUNT_INIT;
      SHIFT:   return PAT_SHIFT_INIT;
      BOUNCE:  return PAT_BOUNCE_INIT;
      default: return PAT_BLINK_INIT;
    endcase
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler producing a one-cycle tick every 2^LOG2DELAY enabled cycles.
module tick_prescaler #(
  parameter int LOG2DELAY = 21
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  logic [LOG2DELAY-1:0] count;

  // Count enabled cycles; the counter wraps naturally at all-ones.
  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // Tick on the last count of each period, only while enabled.
  assign tick = en && (count == '1);

endmodule

// File: rtl/led_pattern_sequencer.sv
// Steps an LED bank through COUNT, SHIFT, BOUNCE and BLINK patterns,
// dwelling a fixed number of prescaler ticks in each or advancing on step.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LOG2DELAY = 21,
  parameter int DWELL     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             step,
  output logic [WIDTH-1:0] led,
  output logic [1:0]       mode,
  output logic             tick
);

  mode_t            state;
  dir_t             dir;
  logic [WIDTH-1:0] pat;
  logic [7:0]       dwell;
  logic             expire;
  logic             advance;

  tick_prescaler #(
    .LOG2DELAY(LOG2DELAY)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  // A step coinciding with dwell expiry still moves only one mode.
  assign expire  = tick && (dwell == 8'(DWELL - 1));
  assign advance = step || expire;

  // Mode FSM and pattern datapath; an advance overrides that tick's pattern update.
  // NOTE: the asynchronous reset clears every register here, so led/mode are valid immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= COUNT;
      dir   <= DIR_LEFT;
      pat   <= '0;
      dwell <= '0;
    end else if (advance) begin
      state <= next_mode(state);
      dir   <= DIR_LEFT;
      pat   <= WIDTH'(entry_pat(next_mode(state)));
      dwell <= '0;
    end else if (tick) begin
      dwell <= dwell + 8'd1;
      case (state)
        COUNT:  pat <= pat + 1'b1;
        SHIFT:  pat <= {pat[WIDTH-2:0], pat[WIDTH-1]};
        BOUNCE: begin
          if (dir == DIR_LEFT) begin
            if (pat == WIDTH'(PAT_MSB)) begin
              dir <= DIR_RIGHT;
              pat <= pat >> 1;
            end else begin
              pat <= pat << 1;
            end
          end else begin
            if (pat == WIDTH'(PAT_LSB)) begin
              dir <= DIR_LEFT;
              pat <= pat << 1;
            end else begin
              pat <= pat >> 1;
            end
          end
        end
        BLINK:  pat <= ~pat;
      endcase
    end
  end

  assign led  = ~pat;
  assign mode = state;

endmodule
